// File: rtl/alu_arbiter.sv
// Four-way round-robin front end sharing one 16-bit ALU into a single-entry response slot.
// Latency 1 cycle; the slot holds while rsp_ready is low and grants stall until it can reload.

module alu_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [3:0]  op_i,
    output logic [15:0] res_o,
    output logic        err_o
);
    always_comb begin
        res_o = 16'h0000;
        unique case (op_i)
            4'd0:    res_o = a_i + b_i;
            4'd1:    res_o = a_i - b_i;
            4'd2:    res_o = a_i & b_i;
            4'd3:    res_o = a_i | b_i;
            4'd4:    res_o = a_i ^ b_i;
            4'd5:    res_o = {a_i[14:0], 1'b0};
            4'd6:    res_o = {1'b0, a_i[15:1]};
            default: res_o = 16'h0000;
        endcase
    end

    assign err_o = (op_i > 4'd6);
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [15:0] req_op,
    output logic [3:0]  req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_id,
    output logic        rsp_err,
    output logic [15:0] op_count
);
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic [1:0]  rsp_id_q,    rsp_id_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [15:0] op_count_q,  op_count_d;
    logic [1:0]  last_grant_q, last_grant_d;

    logic        win_found;
    logic [1:0]  win_idx;
    logic        can_accept;
    logic        xfer;
    logic [15:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        alu_err;

    // Search starts one past the last winner; k=4 wraps back to last_grant itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && req_valid[last_grant_q + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = last_grant_q + 2'(k);
            end
        end
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    // rst_n gating keeps req_ready low for the entire reset window.
    assign xfer       = win_found && can_accept && rst_n;
    assign req_ready  = xfer ? (4'b0001 << win_idx) : 4'b0000;

    assign alu_a  = req_a[{win_idx, 4'b0000} +: 16];
    assign alu_b  = req_b[{win_idx, 4'b0000} +: 16];
    assign alu_op = req_op[{win_idx, 2'b00} +: 4];

    alu_16bit u_alu (
        .a_i   (alu_a),
        .b_i   (alu_b),
        .op_i  (alu_op),
        .res_o (alu_res),
        .err_o (alu_err)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = alu_res;
            rsp_id_d     = win_idx;
            rsp_err_d    = alu_err;
            last_grant_d = win_idx;
            if (op_count_q != 16'hFFFF) begin
                op_count_d = op_count_q + 16'd1;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_id_q     <= 2'd0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= 16'h0000;
            last_grant_q <= 2'd3;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;
endmodule
